tbus_mem_responder: RTL and testbench

- Responder end of the trinity bus (tbus): accepts single-beat read/write/flush requests from a requester (load/store unit or the arbiter in front of it) and returns read data plus a one-cycle completion pulse.
- Backed by an internal 64-bit-wide word memory with configurable fixed access latency and a power-up clear sweep.
- Serves as the memory-side model/endpoint behind the tbus arbiter for core bring-up and unit-level verification of the LSU.

---
 rtl/tbus_mem_responder_if.sv | 23 ++
 rtl/tbus_mem_responder.sv | 113 +++++++++++
 tb/tb_tbus_mem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tbus_mem_responder_if.sv
// Trinity bus (tbus) single-beat request/response bundle.
// The master drives requests; the slave (memory responder) answers with done/data/error.
interface tbus_mem_responder_if;
  logic        tbus_index_valid;
  logic        tbus_index_ready;
  logic [63:0] tbus_index;
  logic [63:0] tbus_write_data;
  logic [63:0] tbus_write_mask;
  logic [1:0]  tbus_operation_type;
  logic [63:0] tbus_read_data;
  logic        tbus_operation_done;
  logic        tbus_error;

  modport master (
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    input  tbus_index_ready, tbus_read_data, tbus_operation_done, tbus_error
  );

  modport slave (
    input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    output tbus_index_ready, tbus_read_data, tbus_operation_done, tbus_error
  );
endinterface

// File: rtl/tbus_mem_responder.sv
// tbus memory responder: 64-bit word memory with a fixed access latency,
// a power-up clear sweep and one outstanding request at a time.
module tbus_mem_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  tbus_mem_responder_if.slave     tbus
);
  localparam int          AW     = $clog2(DEPTH);
  localparam logic [63:0] SPAN   = 64'(DEPTH) << 3;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [3:0]    r_cnt;
  logic [63:0]   r_idx, r_wd, r_mask;
  logic [1:0]    r_op;
  logic          r_done, r_err;
  logic [63:0]   r_rdata;
  logic [63:0]   mem [DEPTH];

  logic          w_accept;
  logic [63:0]   w_src_idx;
  logic [1:0]    w_src_op;
  logic          w_src_inr, w_wr_inr;
  logic [AW-1:0] w_src_word, w_wr_word;

  function automatic logic in_rng(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [63:0] a);
    return AW'((a - BASE) >> 3);
  endfunction

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_INIT: if (r_ptr == AW'(DEPTH - 1)) w_next = S_IDLE;
      S_IDLE: if (tbus.tbus_index_valid) begin
        w_accept = 1'b1;
        w_next   = (LATENCY == 1) ? S_RESP : S_BUSY;
      end
      S_BUSY: if (r_cnt <= 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  // Response is formed on the edge entering RESP; with LATENCY=1 that is the
  // acceptance edge itself, so the live bus fields are the source then.
  assign w_src_idx  = (r_state == S_IDLE) ? tbus.tbus_index : r_idx;
  assign w_src_op   = (r_state == S_IDLE) ? tbus.tbus_operation_type : r_op;
  assign w_src_inr  = in_rng(w_src_idx);
  assign w_src_word = word_of(w_src_idx);
  assign w_wr_inr   = in_rng(r_idx);
  assign w_wr_word  = word_of(r_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wd    <= '0;
      r_mask  <= '0;
      r_op    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT) r_ptr <= r_ptr + 1'b1;
      if (w_accept) begin
        r_idx  <= tbus.tbus_index;
        r_wd   <= tbus.tbus_write_data;
        r_mask <= tbus.tbus_write_mask;
        r_op   <= tbus.tbus_operation_type;
        r_cnt  <= LAT_M1;
      end else if (r_state == S_BUSY) begin
        r_cnt  <= r_cnt - 1'b1;
      end
      r_done  <= (w_next == S_RESP);
      r_err   <= 1'b0;
      r_rdata <= '0;
      // op[1] set means FLUSH (or reserved): never range-checked
      if (w_next == S_RESP && !w_src_op[1]) begin
        if (!w_src_inr)          r_err   <= 1'b1;
        else if (!w_src_op[0])   r_rdata <= mem[w_src_word];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == S_INIT)
        mem[r_ptr] <= '0;
      else if (r_state == S_RESP && r_op == 2'd1 && w_wr_inr)
        mem[w_wr_word] <= (mem[w_wr_word] & ~r_mask) | (r_wd & r_mask);
    end
  end

  assign tbus.tbus_index_ready    = (r_state == S_IDLE);
  assign tbus.tbus_operation_done = r_done;
  assign tbus.tbus_error          = r_err;
  assign tbus.tbus_read_data      = r_rdata;
endmodule

// File: tb/tb_tbus_mem_responder.sv
// Bench for tbus_mem_responder: three DEPTH=16 instances (LATENCY 2, 1, 4)
// checked against an array-based memory model.
module tb_tbus_mem_responder;
  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LATS [3] = '{2, 1, 4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vld [3];
  logic [63:0] idx [3];
  logic [63:0] wd  [3];
  logic [63:0] msk [3];
  logic [1:0]  op  [3];
  logic        rdy [3];
  logic        dn  [3];
  logic        er  [3];
  logic [63:0] rd  [3];

  logic [63:0] model [3][DEPTH];
  int total = 0;
  int bad   = 0;

  tbus_mem_responder_if if0 ();
  tbus_mem_responder_if if1 ();
  tbus_mem_responder_if if2 ();

  tbus_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) u0 (.clock(clk), .reset(rst), .tbus(if0));
  tbus_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u1 (.clock(clk), .reset(rst), .tbus(if1));
  tbus_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(4)) u2 (.clock(clk), .reset(rst), .tbus(if2));

  assign if0.tbus_index_valid = vld[0]; assign if1.tbus_index_valid = vld[1]; assign if2.tbus_index_valid = vld[2];
  assign if0.tbus_index = idx[0];       assign if1.tbus_index = idx[1];       assign if2.tbus_index = idx[2];
  assign if0.tbus_write_data = wd[0];   assign if1.tbus_write_data = wd[1];   assign if2.tbus_write_data = wd[2];
  assign if0.tbus_write_mask = msk[0];  assign if1.tbus_write_mask = msk[1];  assign if2.tbus_write_mask = msk[2];
  assign if0.tbus_operation_type = op[0]; assign if1.tbus_operation_type = op[1]; assign if2.tbus_operation_type = op[2];
  assign rdy[0] = if0.tbus_index_ready;  assign rdy[1] = if1.tbus_index_ready;  assign rdy[2] = if2.tbus_index_ready;
  assign dn[0]  = if0.tbus_operation_done; assign dn[1] = if1.tbus_operation_done; assign dn[2] = if2.tbus_operation_done;
  assign er[0]  = if0.tbus_error;        assign er[1]  = if1.tbus_error;        assign er[2]  = if2.tbus_error;
  assign rd[0]  = if0.tbus_read_data;    assign rd[1]  = if1.tbus_read_data;    assign rd[2]  = if2.tbus_read_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < DEPTH; w++) model[d][w] = '0;
  endtask

  // Expected outcome straight from the address map and merge rule.
  task automatic model_op(input int d, input logic [1:0] o, input logic [63:0] a,
                          input logic [63:0] w, input logic [63:0] m,
                          output logic [63:0] erd, output logic eerr);
    int wi;
    erd = '0; eerr = 1'b0;
    if (o >= 2'd2) return;
    if (a < BASE || (a - BASE) >= 64'(DEPTH * 8)) begin eerr = 1'b1; return; end
    wi = int'((a - BASE) / 64'd8);
    if (o == 2'd0) erd = model[d][wi];
    else model[d][wi] = (model[d][wi] & ~m) | (w & m);
  endtask

  task automatic do_req(input int d, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] w, input logic [63:0] m, input string tag);
    logic [63:0] erd; logic eerr; int n; int k; int rdy_hi;
    model_op(d, o, a, w, m, erd, eerr);
    @(negedge clk);
    op[d] = o; idx[d] = a; wd[d] = w; msk[d] = m; vld[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_ready_seen"}, 64'(rdy[d]), 64'd1);
    @(negedge clk);
    vld[d] = 1'b0;
    op[d] = 2'($urandom); idx[d] = {$urandom, $urandom}; wd[d] = {$urandom, $urandom}; msk[d] = {$urandom, $urandom};
    k = 1; rdy_hi = 0;
    while (!dn[d] && k < 50) begin
      if (rdy[d]) rdy_hi++;
      @(negedge clk); k++;
    end
    if (rdy[d]) rdy_hi++;
    chk({tag, "_latency"}, 64'(k), 64'(LATS[d]));
    chk({tag, "_ready_low"}, 64'(rdy_hi), 64'd0);
    chk({tag, "_rdata"}, rd[d], erd);
    chk({tag, "_error"}, 64'(er[d]), 64'(eerr));
    @(negedge clk);
    chk({tag, "_after"}, {60'd0, dn[d], er[d], rdy[d], |rd[d]}, 64'b0010);
  endtask

  task automatic wait_init(input string tag);
    int n [3]; int dpulse; logic all_rdy;
    n = '{0, 0, 0}; dpulse = 0;
    for (int c = 0; c < 60; c++) begin
      all_rdy = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (!rdy[d]) begin n[d]++; all_rdy = 1'b0; end
        if (dn[d]) dpulse++;
      end
      if (all_rdy) break;
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) chk($sformatf("%s_init_len%0d", tag, d), 64'(n[d]), 64'(DEPTH));
    chk({tag, "_init_no_done"}, 64'(dpulse), 64'd0);
  endtask

  task automatic b2b(input int d, input string tag);
    int acc [$]; int dcount; int cyc; int extra;
    @(negedge clk);
    op[d] = 2'd0; idx[d] = BASE; vld[d] = 1'b1;
    dcount = 0; cyc = 0;
    while ((acc.size() < 3 || dcount < 3) && cyc < 100) begin
      if (dn[d]) dcount++;
      if (vld[d] && rdy[d]) acc.push_back(cyc);
      @(negedge clk); cyc++;
      if (acc.size() == 3) vld[d] = 1'b0;
      else idx[d] = BASE + 64'(8 * acc.size());
    end
    extra = 0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (dn[d]) extra++; end
    chk({tag, "_accepts"}, 64'(acc.size()), 64'd3);
    chk({tag, "_dones"}, 64'(dcount + extra), 64'd3);
    if (acc.size() == 3) begin
      chk({tag, "_gap1"}, 64'(acc[1] - acc[0]), 64'(LATS[d] + 1));
      chk({tag, "_gap2"}, 64'(acc[2] - acc[1]), 64'(LATS[d] + 1));
    end
  endtask

  initial begin
    int k; logic [63:0] a; logic [1:0] o; logic [63:0] m;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0; idx[d] = '0; wd[d] = '0; msk[d] = '0; op[d] = '0;
    end
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {60'd0, rdy[0], dn[0], er[0], |rd[0]}, 64'd0);
    rst = 1'b0;
    wait_init("por");

    do_req(0, 2'd0, 64'h8000_0040, '0, '0, "rd_cleared");
    do_req(0, 2'd1, 64'h8000_0008, 64'h1122_3344_5566_7788, '1, "wr_full");
    do_req(0, 2'd0, 64'h8000_0008, '0, '0, "rd_full");
    do_req(0, 2'd1, 64'h8000_0008, 64'h0000_0000_AB00_0000, 64'h0000_0000_FF00_0000, "wr_part");
    do_req(0, 2'd0, 64'h8000_0008, '0, '0, "rd_part");
    chk("rd_part_const", model[0][1], 64'h1122_3344_AB66_7788);
    do_req(0, 2'd0, 64'h7FFF_FFF8, '0, '0, "rd_below");
    do_req(0, 2'd0, BASE + 64'(DEPTH * 8), '0, '0, "rd_above");
    do_req(0, 2'd1, BASE + 64'(DEPTH * 8), '1, '1, "wr_above");
    do_req(0, 2'd0, 64'h8000_0000, '0, '0, "rd_word0");
    do_req(0, 2'd0, 64'h8000_000F, '0, '0, "rd_lowbits");
    do_req(0, 2'd2, 64'h0, '0, '0, "flush");
    do_req(0, 2'd3, 64'h0, '0, '0, "rsvd_op");

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 19));
      a = (k == 19) ? (BASE - 64'(8 * $urandom_range(1, 4))) : (BASE + 64'(8 * k));
      a = a + 64'($urandom_range(0, 7));
      o = 2'($urandom_range(0, 3));
      m = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
      do_req(0, o, a, {$urandom, $urandom}, m, $sformatf("rnd%0d", i));
    end

    b2b(1, "b2b_lat1");
    b2b(2, "b2b_lat4");

    @(negedge clk);
    op[0] = 2'd1; idx[0] = 64'h8000_0010; wd[0] = 64'hDEAD_BEEF_CAFE_F00D; msk[0] = '1; vld[0] = 1'b1;
    k = 0;
    while (!rdy[0] && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    vld[0] = 1'b0;
    chk("midrst_busy", 64'(rdy[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", {62'd0, dn[0], rdy[0]}, 64'd0);
    rst = 1'b0;
    model_clear();
    wait_init("midrst");
    do_req(0, 2'd0, 64'h8000_0010, '0, '0, "midrst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
